// File: rtl/sha256_multiblock_core.sv
// sha256_multiblock_core
// SHA-224/SHA-256 compression engine with multi-block chaining.
// Takes pre-padded 512-bit blocks on a valid/ready handshake and runs UNROLL rounds per clock.
// The intermediate hash is chained across blocks. The digest is returned on a valid/yumi handshake.
//
// Ports
//   clk_i     clock, all state updates on posedge
//   reset_i   synchronous active-high reset
//   en_i      global enable; 0 freezes every register
//   v_i       block_i/first_i/last_i/mode_i valid
//   ready_o   core can accept a block this cycle
//   block_i   padded block, [511:480] = W0 ... [31:0] = W15
//   first_i   1 = start new message from IV, 0 = continue chained H
//   last_i    1 = final block, digest produced after it
//   mode_i    0 = SHA-256, 1 = SHA-224 (sampled only with first_i=1)
//   v_o       digest_o valid
//   yumi_i    consumer takes digest_o
//   digest_o  [255:224] = H0 ... [31:0] = H7 (zero for SHA-224)

module sha256_multiblock_core #(
  parameter int unsigned UNROLL    = 1,
  parameter bit          KT_IN_ROM = 1'b1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         en_i,
  input  logic         v_i,
  output logic         ready_o,
  input  logic [511:0] block_i,
  input  logic         first_i,
  input  logic         last_i,
  input  logic         mode_i,
  output logic         v_o,
  input  logic         yumi_i,
  output logic [255:0] digest_o
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned ROUNDS = 64;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS);
  localparam logic [CNT_W-1:0] STEP     = CNT_W'(UNROLL);

  localparam logic [255:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  // Round constants as a flat table (used when KT_IN_ROM = 0)
  localparam logic [WORD_W-1:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef enum logic [1:0] {eIdle, eBusy, eAdd, eDone} state_e;

  state_e            state;
  logic [CNT_W-1:0]  cnt_q;
  logic              mode_q;
  logic              last_q;
  logic [WORD_W-1:0] w_q   [16];
  logic [WORD_W-1:0] s_q   [8];
  logic [WORD_W-1:0] h_q   [8];
  logic [WORD_W-1:0] w_nx  [16];
  logic [WORD_W-1:0] s_nx  [8];
  logic [WORD_W-1:0] h_sum [8];
  logic [255:0]      digest_nx;
  logic [WORD_W-1:0] t1;
  logic [WORD_W-1:0] t2;
  logic [WORD_W-1:0] w_new;
  logic [5:0]        rnd;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] bsig0(input logic [WORD_W-1:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [WORD_W-1:0] bsig1(input logic [WORD_W-1:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [WORD_W-1:0] iv_word(input logic m, input int i);
    logic [255:0] v;
    v = m ? IV224 : IV256;
    return v[255-32*i -: 32];
  endfunction

  // Round constant ROM addressed by the round number
  function automatic logic [WORD_W-1:0] k_rom(input logic [5:0] t);
    logic [WORD_W-1:0] k;
    k = '0;
    case (t)
      6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;  6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;  6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;  6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;  6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;  6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;  6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;  6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;  6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;  6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;  6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;  6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;  6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;  6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;  6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;  6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;  6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
      default: k = '0;
    endcase
    return k;
  endfunction

  function automatic logic [WORD_W-1:0] k_of(input logic [5:0] t);
    if (KT_IN_ROM) return k_rom(t);
    else           return K_TAB[t];
  endfunction

  // UNROLL rounds per cycle; w_nx[0] always holds W[t] for the round being computed,
  // and W[t+16] is appended at the top of the 16-word window after each round.
  always_comb begin
    w_nx  = w_q;
    s_nx  = s_q;
    t1    = '0;
    t2    = '0;
    w_new = '0;
    rnd   = '0;
    for (int unsigned u = 0; u < UNROLL; u++) begin
      rnd = 6'(cnt_q) + 6'(u);
      t1  = s_nx[7] + bsig1(s_nx[4]) + ch(s_nx[4], s_nx[5], s_nx[6]) + k_of(rnd) + w_nx[0];
      t2  = bsig0(s_nx[0]) + maj(s_nx[0], s_nx[1], s_nx[2]);
      for (int j = 7; j > 0; j--) s_nx[j] = s_nx[j-1];
      s_nx[4] = s_nx[4] + t1;
      s_nx[0] = t1 + t2;
      w_new = ssig1(w_nx[14]) + w_nx[9] + ssig0(w_nx[1]) + w_nx[0];
      for (int j = 0; j < 15; j++) w_nx[j] = w_nx[j+1];
      w_nx[15] = w_new;
    end
  end

  // Feed-forward sum and packed digest (H7 zeroed for SHA-224)
  always_comb begin
    h_sum     = h_q;
    digest_nx = '0;
    for (int i = 0; i < 8; i++) begin
      h_sum[i] = h_q[i] + s_q[i];
      digest_nx[255-32*i -: 32] = h_sum[i];
    end
    if (mode_q) digest_nx[31:0] = '0;
  end

  // Control FSM and all datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= eIdle;
      ready_o  <= 1'b1;
      v_o      <= 1'b0;
      digest_o <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      last_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        h_q[i] <= iv_word(1'b0, i);
        s_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else if (en_i) begin
      unique case (state)
        eIdle: begin
          if (v_i && ready_o) begin
            for (int i = 0; i < 16; i++) w_q[i] <= block_i[511-32*i -: 32];
            if (first_i) begin
              mode_q <= mode_i;
              for (int i = 0; i < 8; i++) begin
                s_q[i] <= iv_word(mode_i, i);
                h_q[i] <= iv_word(mode_i, i);
              end
            end else begin
              for (int i = 0; i < 8; i++) s_q[i] <= h_q[i];
            end
            last_q  <= last_i;
            ready_o <= 1'b0;
            state   <= eBusy;
          end
        end
        eBusy: begin
          w_q   <= w_nx;
          s_q   <= s_nx;
          cnt_q <= cnt_q + STEP;
          if (cnt_q + STEP == LAST_CNT) state <= eAdd;
        end
        eAdd: begin
          cnt_q <= '0;
          h_q   <= h_sum;
          if (last_q) begin
            digest_o <= digest_nx;
            v_o      <= 1'b1;
            state    <= eDone;
          end else begin
            ready_o <= 1'b1;
            state   <= eIdle;
          end
        end
        eDone: begin
          // Restart from IV so a following first_i=0 block starts a fresh message
          if (yumi_i) begin
            v_o     <= 1'b0;
            ready_o <= 1'b1;
            state   <= eIdle;
            for (int i = 0; i < 8; i++) h_q[i] <= iv_word(mode_q, i);
          end
        end
        default: state <= eIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_multiblock_core.sv
// tb_sha256_multiblock_core
// Drives four core instances (UNROLL 1/2/4/8, both Kt styles) through known-answer
// vectors, chaining/abort/enable corner cases and random multi-block messages checked
// against a straightforward SHA-256 compression model.

module tb_sha256_multiblock_core;

  localparam int unsigned NDUT = 4;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

  localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO2  = {480'h0, 32'h000001c0};

  localparam logic [255:0] D_ABC256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_ABC224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] D_TWO    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] D_EMPTY  = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  typedef struct {
    logic [511:0] blk;
    logic         first;
    logic         last;
    logic         mode;
    int           hold;
    logic [255:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         en    [NDUT];
  logic         v_i   [NDUT];
  logic         ready [NDUT];
  logic [511:0] blk   [NDUT];
  logic         first [NDUT];
  logic         last  [NDUT];
  logic         mode  [NDUT];
  logic         v_o   [NDUT];
  logic         yumi  [NDUT];
  logic [255:0] dig   [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    sha256_multiblock_core #(.UNROLL(1 << g), .KT_IN_ROM((g % 2) == 0)) dut (
      .clk_i(clk), .reset_i(reset), .en_i(en[g]), .v_i(v_i[g]), .ready_o(ready[g]),
      .block_i(blk[g]), .first_i(first[g]), .last_i(last[g]), .mode_i(mode[g]),
      .v_o(v_o[g]), .yumi_i(yumi[g]), .digest_o(dig[g]));
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] b);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  x1, x2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = h[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      x1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[i] + w[i];
      x2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + x1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = h[255-32*i -: 32] + v[i];
    return r;
  endfunction

  // ---------------- comparison helpers ----------------
  task automatic chk_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one block once ready_o is up; returns at the negedge after the accepting edge
  task automatic send(input int d, input logic [511:0] b, input logic f, input logic l, input logic m);
    int k = 0;
    while (ready[d] !== 1'b1 && k < 300) begin
      step();
      k++;
    end
    chk_bit("ready_before_send", ready[d], 1'b1);
    en[d] = 1'b1; v_i[d] = 1'b1; blk[d] = b; first[d] = f; last[d] = l; mode[d] = m;
    step();
    v_i[d] = 1'b0; first[d] = 1'b0; last[d] = 1'b0; mode[d] = 1'b0;
  endtask

  // Run until the block finishes; optional en_i gaps and junk v_i/yumi_i while busy
  task automatic wait_done(input int d, input logic l, input logic [255:0] exp, input bit gaps, input bit junk);
    int edges = 0;
    int en_edges = 0;
    int gap_left = 0;
    int lat = 64 / (1 << d) + 1;
    bit seen = 1'b0;
    bit stray = 1'b0;
    while (!seen && edges < 600) begin
      if (gaps && gap_left == 0 && $urandom_range(0, 5) == 0) gap_left = int'($urandom_range(1, 5));
      en[d] = (gap_left == 0);
      if (gap_left > 0) gap_left--;
      if (junk) begin
        v_i[d]   = 1'($urandom_range(0, 1));
        yumi[d]  = 1'($urandom_range(0, 1));
        first[d] = 1'($urandom_range(0, 1));
        last[d]  = 1'($urandom_range(0, 1));
        mode[d]  = 1'($urandom_range(0, 1));
        for (int j = 0; j < 16; j++) blk[d][511-32*j -: 32] = $urandom();
      end
      step();
      edges++;
      if (en[d]) en_edges++;
      if (v_o[d] && !l) stray = 1'b1;
      seen = l ? v_o[d] : ready[d];
    end
    en[d] = 1'b1; v_i[d] = 1'b0; yumi[d] = 1'b0; first[d] = 1'b0; last[d] = 1'b0; mode[d] = 1'b0;
    chk_bit("block_completes", seen, 1'b1);
    chk_int($sformatf("latency_u%0d", 1 << d), en_edges, lat);
    if (l) begin
      chk_vec($sformatf("digest_u%0d", 1 << d), dig[d], exp);
      chk_bit("ready_low_in_done", ready[d], 1'b0);
    end else begin
      chk_bit("no_vo_mid_message", stray, 1'b0);
    end
  endtask

  // Hold the digest for a while, try a gated yumi, then take it with a competing block offered
  task automatic do_yumi(input int d, input int hold, input logic [255:0] exp);
    for (int i = 0; i < hold; i++) begin
      step();
      chk_vec("hold_digest", dig[d], exp);
      chk_bit("hold_ready_low", ready[d], 1'b0);
    end
    if (hold > 0) begin
      en[d] = 1'b0; yumi[d] = 1'b1;
      step();
      en[d] = 1'b1;
      chk_bit("yumi_needs_en", v_o[d], 1'b1);
    end
    yumi[d] = 1'b1; v_i[d] = 1'b1; blk[d] = EMPTY; first[d] = 1'b1; last[d] = 1'b1;
    step();
    yumi[d] = 1'b0; v_i[d] = 1'b0; first[d] = 1'b0; last[d] = 1'b0;
    chk_bit("vo_drop_after_yumi", v_o[d], 1'b0);
    chk_bit("ready_after_yumi", ready[d], 1'b1);
  endtask

  vec_t tab [5];

  initial begin
    logic [255:0] h;
    logic [255:0] exp;
    logic [511:0] rb;
    logic         md;
    int           nb;

    tab[0] = '{ABC,   1'b1, 1'b1, 1'b0, 0,  D_ABC256};
    tab[1] = '{ABC,   1'b1, 1'b1, 1'b1, 0,  D_ABC224};
    tab[2] = '{TWO1,  1'b1, 1'b0, 1'b0, 0,  256'h0};
    tab[3] = '{TWO2,  1'b0, 1'b1, 1'b0, 0,  D_TWO};
    tab[4] = '{EMPTY, 1'b1, 1'b1, 1'b0, 10, D_EMPTY};

    reset = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      en[d] = 1'b1; v_i[d] = 1'b0; blk[d] = '0; first[d] = 1'b0;
      last[d] = 1'b0; mode[d] = 1'b0; yumi[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      chk_bit("reset_ready", ready[d], 1'b1);
      chk_bit("reset_vo", v_o[d], 1'b0);
      chk_vec("reset_digest", dig[d], 256'h0);
    end

    for (int d = 0; d < NDUT; d++) begin
      // Known-answer table
      for (int i = 0; i < 5; i++) begin
        send(d, tab[i].blk, tab[i].first, tab[i].last, tab[i].mode);
        wait_done(d, tab[i].last, tab[i].exp, 1'b0, 1'b0);
        if (tab[i].last) do_yumi(d, tab[i].hold, tab[i].exp);
      end

      // After a yumi the chain is back at IV: first_i=0 behaves as a new message
      send(d, ABC, 1'b0, 1'b1, 1'b0);
      wait_done(d, 1'b1, D_ABC256, 1'b0, 1'b0);
      do_yumi(d, 0, D_ABC256);

      // first_i=1 mid-message discards the chain
      send(d, TWO1, 1'b1, 1'b0, 1'b0);
      wait_done(d, 1'b0, 256'h0, 1'b0, 1'b0);
      send(d, ABC, 1'b1, 1'b1, 1'b1);
      wait_done(d, 1'b1, D_ABC224, 1'b0, 1'b0);
      do_yumi(d, 0, D_ABC224);

      // Reset around round 30, then resend with first_i=0 (mode_i ignored)
      send(d, ABC, 1'b1, 1'b1, 1'b1);
      repeat (30 >> d) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_bit("abort_vo", v_o[d], 1'b0);
      chk_bit("abort_ready", ready[d], 1'b1);
      chk_vec("abort_digest", dig[d], 256'h0);
      send(d, ABC, 1'b0, 1'b1, 1'b1);
      wait_done(d, 1'b1, D_ABC256, 1'b0, 1'b0);
      do_yumi(d, 0, D_ABC256);

      // Two-block message with en_i gaps
      send(d, TWO1, 1'b1, 1'b0, 1'b0);
      wait_done(d, 1'b0, 256'h0, 1'b1, 1'b0);
      send(d, TWO2, 1'b0, 1'b1, 1'b0);
      wait_done(d, 1'b1, D_TWO, 1'b1, 1'b0);
      do_yumi(d, 2, D_TWO);

      // Random messages against the model, with gaps and junk while busy
      for (int m = 0; m < 5; m++) begin
        nb = int'($urandom_range(1, 3));
        md = 1'($urandom_range(0, 1));
        h  = md ? IV224 : IV256;
        exp = '0;
        for (int b = 0; b < nb; b++) begin
          for (int j = 0; j < 16; j++) rb[511-32*j -: 32] = $urandom();
          h   = compress(h, rb);
          exp = md ? {h[255:32], 32'h0} : h;
          send(d, rb, b == 0, b == nb - 1, (b == 0) ? md : ~md);
          wait_done(d, b == nb - 1, exp, 1'b1, 1'b1);
        end
        do_yumi(d, int'($urandom_range(0, 3)), exp);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
